// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit feeding the register file dual-write path.
// MUL: shift-add, multiplier LSB first. DIV: restoring, dividend MSB first.
// RUN holds for W iteration edges plus one result-transfer edge, so Done is high in the
// cycle after edge W+1 and Busy covers W+2 cycles.
module mul_div_unit #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_op_a,
  input  logic [W-1:0] i_op_b,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_wr_en,
  output logic [W-1:0] o_hi_out,
  output logic [W-1:0] o_lo_out,
  output logic         o_div_zero
);

  localparam logic [2:0]    OpMul   = 3'b100;
  localparam logic [2:0]    OpDiv   = 3'b101;
  localparam logic [CW-1:0] CntLast = CW'(W);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;        // multiplicand (MUL) or divisor (DIV)
  logic [W-1:0]  r_lo;       // multiplier shifting out / dividend shifting out, quotient in
  logic [W:0]    r_rem;      // product high half with carry / partial remainder
  logic          r_is_div;
  logic [W-1:0]  r_hi_out, r_lo_out;
  logic          r_div_zero;

  logic          w_accept, w_last;
  logic [W:0]    w_mul_sum;
  logic [W:0]    w_div_shift;
  logic [W+1:0]  w_div_trial;
  logic          w_div_ok;
  logic [W:0]    w_rem_next;
  logic [W-1:0]  w_lo_next;

  assign w_accept = (r_state == StIdle) && i_start && ((i_op == OpMul) || (i_op == OpDiv));
  assign w_last   = (r_cnt == CntLast);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    o_busy  = (r_state == StRun) || (r_state == StDone);
    o_done  = (r_state == StDone);
    o_wr_en = (r_state == StDone);
  end

  // One iteration step of either operation
  always_comb begin
    w_mul_sum   = {1'b0, r_rem[W-1:0]} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_div_shift = {r_rem[W-1:0], r_lo[W-1]};
    w_div_trial = {1'b0, w_div_shift} - {2'b00, r_a};
    w_div_ok    = ~w_div_trial[W+1];
    if (r_is_div) begin
      // A zero divisor always "fits": quotient saturates to all ones and the
      // dividend shifts through untouched into the remainder.
      w_rem_next = w_div_ok ? w_div_trial[W:0] : w_div_shift;
      w_lo_next  = {r_lo[W-2:0], w_div_ok};
    end else begin
      w_rem_next = {1'b0, w_mul_sum[W:1]};
      w_lo_next  = {w_mul_sum[0], r_lo[W-1:1]};
    end
  end

  // Datapath: latch operands on accept, iterate in RUN, publish results on DONE entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_lo       <= '0;
      r_rem      <= '0;
      r_is_div   <= 1'b0;
      r_hi_out   <= '0;
      r_lo_out   <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_is_div   <= (i_op == OpDiv);
      r_a        <= (i_op == OpDiv) ? i_op_b : i_op_a;
      r_lo       <= (i_op == OpDiv) ? i_op_a : i_op_b;
      r_div_zero <= (i_op == OpDiv) && (i_op_b == '0);
    end else if (r_state == StRun) begin
      if (w_last) begin
        r_hi_out <= r_rem[W-1:0];
        r_lo_out <= r_lo;
      end else begin
        r_rem <= w_rem_next;
        r_lo  <= w_lo_next;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Result outputs
  always_comb begin
    o_hi_out   = r_hi_out;
    o_lo_out   = r_lo_out;
    o_div_zero = r_div_zero;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, results, div-by-zero, ignored starts, async reset.
module tb_mul_div_unit;

  logic        clk, rst_n, start;
  logic [2:0]  op;
  logic [15:0] op_a, op_b;
  logic        busy, done, wr_en, div_zero;
  logic [15:0] hi_out, lo_out;

  int checks   = 0;
  int failures = 0;

  int          done_edge, busy_cycles, done_pulses, wr_mismatch;
  logic [15:0] mid_hi, mid_lo;
  int          busy_seen, done_seen;

  mul_div_unit #(.W(16), .CW(5)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_op       (op),
    .i_op_a     (op_a),
    .i_op_b     (op_b),
    .o_busy     (busy),
    .o_done     (done),
    .o_wr_en    (wr_en),
    .o_hi_out   (hi_out),
    .o_lo_out   (lo_out),
    .o_div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at edge 0 and follow it until Busy drops (bounded).
  // With hold set, Start stays high with scrambled operands during RUN.
  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input bit hold);
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(posedge clk); #1;
    if (hold) begin op_a = 16'hFFFF; op_b = 16'hFFFF; end
    else start = 1'b0;
    done_edge = -1; busy_cycles = busy ? 1 : 0; done_pulses = 0; wr_mismatch = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k >= 12) start = 1'b0;
      if (k == 5) begin mid_hi = hi_out; mid_lo = lo_out; end
      if (busy) busy_cycles++;
      if (done) begin done_pulses++; if (done_edge < 0) done_edge = k; end
      if (wr_en !== done) wr_mismatch++;
      if (!busy) break;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b000; op_a = '0; op_b = '0;
    #22;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", {16'd0, hi_out}, 32'd0);
    check("reset_lo", {16'd0, lo_out}, 32'd0);
    check("reset_dz", {31'd0, div_zero}, 32'd0);
    rst_n = 1'b1;

    // T1
    run_op(3'b100, 16'h00FF, 16'h0101, 1'b0);
    check("t1_done_edge", done_edge, 32'd17);
    check("t1_hi", {16'd0, hi_out}, 32'h0000);
    check("t1_lo", {16'd0, lo_out}, 32'hFFFF);
    check("t1_dz", {31'd0, div_zero}, 32'd0);

    // T2: also outputs must hold T1 values mid-run
    run_op(3'b100, 16'hFFFF, 16'hFFFF, 1'b0);
    check("t2_mid_lo_hold", {16'd0, mid_lo}, 32'hFFFF);
    check("t2_busy_cycles", busy_cycles, 32'd18);
    check("t2_hi", {16'd0, hi_out}, 32'hFFFE);
    check("t2_lo", {16'd0, lo_out}, 32'h0001);

    // T3
    run_op(3'b101, 16'h0064, 16'h0007, 1'b0);
    check("t3_lo", {16'd0, lo_out}, 32'h000E);
    check("t3_hi", {16'd0, hi_out}, 32'h0002);
    check("t3_done_pulses", done_pulses, 32'd1);
    check("t3_wren_eq_done", wr_mismatch, 32'd0);

    // T4
    run_op(3'b101, 16'h1234, 16'h0000, 1'b0);
    check("t4_done_edge", done_edge, 32'd17);
    check("t4_lo", {16'd0, lo_out}, 32'hFFFF);
    check("t4_hi", {16'd0, hi_out}, 32'h1234);
    check("t4_dz", {31'd0, div_zero}, 32'd1);
    run_op(3'b100, 16'h0002, 16'h0003, 1'b0);
    check("t4_mul_lo", {16'd0, lo_out}, 32'h0006);
    check("t4_mul_dz", {31'd0, div_zero}, 32'd0);

    // Division boundaries
    run_op(3'b101, 16'hFFFF, 16'h0001, 1'b0);
    check("div_by1_lo", {16'd0, lo_out}, 32'hFFFF);
    check("div_by1_hi", {16'd0, hi_out}, 32'h0000);
    run_op(3'b101, 16'h0005, 16'h0009, 1'b0);
    check("div_small_lo", {16'd0, lo_out}, 32'h0000);
    check("div_small_hi", {16'd0, hi_out}, 32'h0005);

    // T5: held Start with changed operands during RUN is ignored
    run_op(3'b100, 16'h0010, 16'h0020, 1'b1);
    check("t5_done_pulses", done_pulses, 32'd1);
    check("t5_hi", {16'd0, hi_out}, 32'h0000);
    check("t5_lo", {16'd0, lo_out}, 32'h0200);
    @(negedge clk);
    start = 1'b1; op = 3'b010; op_a = 16'h0001; op_b = 16'h0001;
    busy_seen = 0; done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (busy) busy_seen++;
      if (done) done_seen++;
    end
    start = 1'b0;
    check("t5_badop_busy", busy_seen, 32'd0);
    check("t5_badop_done", done_seen, 32'd0);

    // T6: async reset in the middle of RUN
    @(negedge clk);
    start = 1'b1; op = 3'b100; op_a = 16'h1111; op_b = 16'h2222;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_done", {31'd0, done}, 32'd0);
    check("t6_rst_hi", {16'd0, hi_out}, 32'd0);
    check("t6_rst_lo", {16'd0, lo_out}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("t6_no_done", done_seen, 32'd0);
    run_op(3'b100, 16'h0003, 16'h0005, 1'b0);
    check("t6_mul_lo", {16'd0, lo_out}, 32'h000F);
    check("t6_mul_hi", {16'd0, hi_out}, 32'h0000);
    check("t6_done_edge", done_edge, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
